fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter FIFO_WIDTH, default 8, SHALL set the data width of every data port.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set the number of entries in the downstream FIFO.
REQ-003 Parameter ADDR_SIZE, default 4, SHALL equal log2(FIFO_DEPTH); level SHALL be ADDR_SIZE+1 bits wide.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 req0  input  1  SHALL be the requester-0 write request, held until granted.
REQ-007 data0  input  FIFO_WIDTH  SHALL be the requester-0 write data, stable while req0=1.
REQ-008 gnt0  output  1  SHALL be the requester-0 accept strobe.
REQ-009 req1  input  1  SHALL be the requester-1 write request.
REQ-010 data1  input  FIFO_WIDTH  SHALL be the requester-1 write data.
REQ-011 gnt1  output  1  SHALL be the requester-1 accept strobe.
REQ-012 re  input  1  SHALL be a copy of the FIFO read enable, used only for occupancy tracking.
REQ-013 full  input  1  SHALL be the FIFO full flag.
REQ-014 we  output  1  SHALL be the registered FIFO write enable.
REQ-015 data_in  output  FIFO_WIDTH  SHALL be the registered FIFO write data.
REQ-016 level  output  ADDR_SIZE+1  SHALL be the tracked occupancy, 0..FIFO_DEPTH.
REQ-017 err  output  1  SHALL be a sticky overflow-error flag.

Function
REQ-018 Stall SHALL be (level==FIFO_DEPTH) OR full; while stalled, gnt0=gnt1=0.
REQ-019 gnt0/gnt1 SHALL be combinational in the request cycle; at most one SHALL be 1 per cycle.
REQ-020 A grant SHALL occur only when the granted req is 1 and the block is not stalled.
REQ-021 Single requester active and not stalled: that requester SHALL be granted that cycle.
REQ-022 Both requesters active: the requester not granted most recently SHALL win (round-robin).
REQ-023 The last-granted pointer SHALL update only on a grant.
REQ-024 On a grant in cycle N, we SHALL be 1 and data_in SHALL equal the granted data in cycle N+1 (1-cycle latency).
REQ-025 Without a grant in cycle N, we SHALL be 0 in cycle N+1 and data_in SHALL hold its last value.
REQ-026 level SHALL increment on a grant (counting in-flight writes) and decrement on re=1 when level!=0.
REQ-027 Grant and a valid read in the same cycle SHALL leave level unchanged.
REQ-028 re=1 with level==0 SHALL be ignored, with no wrap to FIFO_DEPTH.
REQ-029 A grant is impossible at level==FIFO_DEPTH, so level SHALL never exceed FIFO_DEPTH.
REQ-030 A read at level==FIFO_DEPTH SHALL not permit a grant in the same cycle (no bypass); a grant is allowed from the next cycle.
REQ-031 err SHALL set when we=1 and full=1 in the same cycle, and SHALL stay set until reset.
REQ-032 A requester deasserting req without a grant SHALL cause no state change.

Reset
REQ-033 rst=0 SHALL immediately force gnt0=0, gnt1=0, we=0, data_in=0, level=0, err=0, with the pointer set so requester 0 wins the first contention.
REQ-034 Reset mid-operation SHALL discard any in-flight write: we=0 from reset assertion.
REQ-035 Operation SHALL resume on the first rising clk edge after rst returns to 1.

Verification
REQ-036 Reset then req0=1, data0=8'h0A for one cycle -> gnt0=1 that cycle; next cycle we=1, data_in=8'h0A, level=1.
REQ-037 req0 and req1 held continuously, data 8'hB0/8'hC1 -> gnts alternate 0,1,0,1...; data_in alternates 8'hB0, 8'hC1.
REQ-038 Sixteen grants without re -> level=16; a 17th req is not granted until re=1 is applied, then granted the following cycle.
REQ-039 Grant and re=1 in the same cycle at level=5 -> level stays 5; re=1 at level=0 -> level stays 0.
REQ-040 Force full=1 while we=1 -> err=1 and remains 1 until rst=0.
REQ-041 Assert rst=0 mid-burst between clock edges -> all outputs go to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin write arbiter in front of a FIFO. It registers the
// winning write and tracks the FIFO occupancy, counting writes still in flight.
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_SIZE  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [FIFO_WIDTH-1:0] data0,
    output logic                  gnt0,
    input  logic                  req1,
    input  logic [FIFO_WIDTH-1:0] data1,
    output logic                  gnt1,
    input  logic                  re,
    input  logic                  full,
    output logic                  we,
    output logic [FIFO_WIDTH-1:0] data_in,
    output logic [ADDR_SIZE:0]    level,
    output logic                  err
);

    localparam logic [ADDR_SIZE:0] DEPTH_LVL = (ADDR_SIZE + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_SIZE:0] ONE_LVL   = (ADDR_SIZE + 1)'(1);

    // last_gnt = 1 means requester 1 won most recently, so requester 0 wins next contention
    logic last_gnt;
    logic stall;
    logic grant;
    logic rd_valid;

    // A read at the full level frees space only from the next cycle; no bypass.
    assign stall    = (level == DEPTH_LVL) || full;
    assign rd_valid = re && (level != '0);

    // Gated by rst so grants drop the moment reset asserts, without a clock.
    always_comb begin
        gnt0 = rst && req0 && !stall && (!req1 || last_gnt);
        gnt1 = rst && req1 && !stall && (!req0 || !last_gnt);
    end

    assign grant = gnt0 || gnt1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt <= 1'b1;
            we       <= 1'b0;
            data_in  <= '0;
            level    <= '0;
            err      <= 1'b0;
        end else begin
            we <= grant;
            if (grant) begin
                data_in  <= gnt0 ? data0 : data1;
                last_gnt <= gnt1;
            end
            case ({grant, rd_valid})
                2'b10:   level <= level + ONE_LVL;
                2'b01:   level <= level - ONE_LVL;
                default: level <= level;
            endcase
            if (we && full) begin
                err <= 1'b1;
            end
        end
    end

endmodule
